mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Sequences and shares the single-ported unified memory between the pipeline's fetch stage (IF) and memory stage (MEM, LW/SW). Each access holds a fixed-latency command on the memory port for `MEM_LAT` cycles, then returns a one-cycle `ready` pulse to the owning requester. Data accesses have priority, and a starvation counter bounds how long fetch can wait. The pipeline stalls a stage while its `req` is high and its `ready` has not pulsed.

## Interface
- `AW`, 32: address width.
- `DW`, 32: data width.
- `MEM_LAT`, 2: memory access cycles per transaction, ≥1.
- `STARVE_MAX`, 4: consecutive data grants allowed while `if_req` is pending, ≥1.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `if_req` in 1: fetch read request; held with `if_addr` until `if_ready`.
- `if_addr` in AW: fetch address.
- `if_ready` out 1: one-cycle completion pulse to fetch.
- `if_rdata` out DW: fetch read data, valid with `if_ready`, held afterwards.
- `d_req` in 1: data request; held with `d_we`, `d_addr`, `d_wdata` until `d_ready`.
- `d_we` in 1: 1 = store (SW), 0 = load (LW).
- `d_addr` in AW: data address.
- `d_wdata` in DW: store data.
- `d_ready` out 1: one-cycle completion pulse to MEM.
- `d_rdata` out DW: load data, valid with `d_ready`, held afterwards.
- `mem_en` out 1: memory command valid.
- `mem_we` out 1: memory write enable.
- `mem_addr` out AW: memory address.
- `mem_wdata` out DW: memory write data.
- `mem_rdata` in DW: memory read data, valid in the last BUSY cycle.
- `gnt_data` out 1: 1 while a data access owns the port (BUSY/DONE).

## Operation
- FSM states: IDLE, BUSY, DONE. Latched registers: `owner` (IF/DATA), `cmd_we`, `cmd_addr`, `cmd_wdata`. `cnt` is a `$clog2(MEM_LAT+1)`-bit counter. `starve` is a `$clog2(STARVE_MAX+1)`-bit counter.
- IDLE, no requests: stay in IDLE.
- IDLE, at least one request:
  - Choose the owner. Grant DATA if `d_req` and not (`if_req` and `starve==STARVE_MAX`). Otherwise grant IF.
  - Latch the owner's command. An IF command latches `cmd_we=0`.
  - Set `cnt=0` and go to BUSY.
- BUSY:
  - `mem_en=1`. `mem_we`, `mem_addr`, `mem_wdata` are driven from the latched registers and are stable for the whole of BUSY.
  - `cnt` increments each cycle.
  - Last BUSY cycle (`cnt==MEM_LAT-1`): if `cmd_we==0`, capture `mem_rdata` into the owner's rdata register. Then go to DONE.
- DONE:
  - Pulse the owner's `ready` for exactly one cycle. The other port's `ready` stays 0.
  - `mem_en=0`.
  - Next state is always IDLE, so a requester that sees `ready` can drop or change its request before the next arbitration.
- Starvation counter:
  - On a DATA grant with `if_req` high, `starve` increments, saturating at `STARVE_MAX`.
  - On an IF grant, or on any arbitration with `if_req` low, `starve` clears to 0.
- Stores: `d_rdata` is unchanged and `d_ready` still pulses.
- `if_rdata` and `d_rdata` change only on a completed read by their own port.
- Requester drops `req` mid-transaction: protocol violation. The access still completes and `ready` still pulses.
- `mem_we=1` only while `mem_en=1`. `mem_addr` and `mem_wdata` are don't-care when `mem_en=0` but are registered (no glitching).

## Timing
- Reset (`rst_n` low, asynchronous) forces:
  - state = IDLE, `cnt=0`, `starve=0`;
  - `mem_en`, `mem_we`, `if_ready`, `d_ready`, `gnt_data` = 0;
  - `mem_addr`, `mem_wdata`, `if_rdata`, `d_rdata` = 0.
- Reset mid-BUSY: `mem_en` drops in the same cycle, no `ready` pulse is issued, and the access is abandoned. Held requests are re-arbitrated after reset release.
- All outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.
- Transaction with the request seen in IDLE at cycle 0:
  - BUSY: cycles 1..MEM_LAT.
  - DONE (`ready` pulse): cycle MEM_LAT+1.
  - Next arbitration: cycle MEM_LAT+2.
- Back-to-back throughput: one access per MEM_LAT+2 cycles.
- Request latency with the arbiter idle: MEM_LAT+1 cycles to `ready`.
- Simultaneous `if_req` and `d_req` in IDLE: DATA wins unless `starve==STARVE_MAX`. The loser waits at least MEM_LAT+2 cycles.

## Test plan
Parameters are `MEM_LAT=2`, `STARVE_MAX=4` unless stated.

1. IF read alone:
   - Stimulus: `if_addr=0x40` at cycle 0; memory returns `0xDEADBEEF` in cycle 2.
   - Response: `mem_en=1`, `mem_addr=0x40` in cycles 1–2; `if_ready=1` with `if_rdata=0xDEADBEEF` in cycle 3 only; `d_ready` stays 0.
2. Simultaneous requests (`if_req` and a `d_req` load at 0x100) at cycle 0:
   - Response: `gnt_data=1` in cycles 1–3 and `d_ready` at cycle 3; the IF access arbitrates in cycle 4, occupies BUSY in cycles 5–6, and `if_ready` pulses at cycle 7.
3. Store:
   - Stimulus: `d_we=1`, `d_addr=0x100`, `d_wdata=0x12345678`.
   - Response: `mem_we=1`, `mem_wdata=0x12345678` in cycles 1–2; `d_ready` at cycle 3; `d_rdata` keeps its prior value.
4. Starvation:
   - Stimulus: `d_req` and `if_req` held high continuously.
   - Response: grant order is DATA, DATA, DATA, DATA, IF, DATA…; `starve` returns to 0 after the IF grant.
5. Reset mid-BUSY:
   - Stimulus: `rst_n` low in cycle 1 of a data read.
   - Response: `mem_en` drops immediately and no `ready` pulse occurs. After release, with both requests held, DATA is re-granted and completes normally.
6. `MEM_LAT=1`:
   - Stimulus: single data load.
   - Response: `mem_en` high in cycle 1 only; `d_ready` at cycle 2; next arbitration at cycle 3.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-port signals around mem_port_arbiter.
// Handshake: a requester raises req with its command and holds both until ready
// pulses for one cycle; ready never pulses for a port that did not own the access.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ready;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ready;
  logic [DW-1:0] d_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          gnt_data;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ready, if_rdata, d_ready, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, gnt_data
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ready, if_rdata, d_ready, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, gnt_data
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between fetch and data accesses.
// Data wins arbitration unless fetch has been passed over STARVE_MAX times.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  mem_port_arbiter_if.slave                 bus,
  output logic [1:0]                        dbg_state,
  output logic [$clog2(STARVE_MAX+1)-1:0]   dbg_starve
);
  localparam int CW = $clog2(MEM_LAT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(MEM_LAT - 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic          owner_d;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [CW-1:0] cnt;
  logic [SW-1:0] starve;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] d_rdata_q;
  logic          any_req;
  logic          grant_d;
  logic          last_beat;

  assign any_req   = bus.if_req | bus.d_req;
  assign grant_d   = bus.d_req & ~(bus.if_req & (starve == STARVE_TOP));
  assign last_beat = (state == BUSY) && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = BUSY;
      BUSY:    if (cnt == CNT_LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_d    <= 1'b0;
      cmd_we     <= 1'b0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
      cnt        <= '0;
      starve     <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (state == IDLE) begin
        if (any_req) begin
          owner_d   <= grant_d;
          cmd_we    <= grant_d & bus.d_we;
          cmd_addr  <= grant_d ? bus.d_addr : bus.if_addr;
          cmd_wdata <= grant_d ? bus.d_wdata : '0;
          cnt       <= '0;
        end
        // A pending fetch that loses arbitration ages; anything else resets the count.
        if (bus.if_req && grant_d) begin
          if (starve != STARVE_TOP) starve <= starve + SW'(1);
        end else begin
          starve <= '0;
        end
      end
      if (state == BUSY) cnt <= cnt + CW'(1);
      if (last_beat && !cmd_we) begin
        if (owner_d) d_rdata_q  <= bus.mem_rdata;
        else         if_rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_en    = (state == BUSY);
  assign bus.mem_we    = (state == BUSY) & cmd_we;
  assign bus.mem_addr  = cmd_addr;
  assign bus.mem_wdata = cmd_wdata;
  assign bus.if_ready  = (state == DONE) & ~owner_d;
  assign bus.d_ready   = (state == DONE) & owner_d;
  assign bus.gnt_data  = (state != IDLE) & owner_d;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign dbg_state     = state;
  assign dbg_starve    = starve;
endmodule
